// File: rtl/axil_pkg.sv
// Shared types for the native-memory to AXI4-Lite bridge.
package axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axil_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT_B,
        RD,
        WAIT_R,
        DONE
    } bridge_state_t;

    localparam int unsigned PROT_INSTR = 2;
    localparam int unsigned ERR_WIDTH  = 16;

endpackage

// File: rtl/mem_axil_bridge.sv
// CPU native memory port (one outstanding access) to AXI4-Lite master.
// One AXI transaction per request, completion signalled by a one-cycle mem_ready pulse.
module mem_axil_bridge
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [STRB_WIDTH-1:0] mem_wstrb,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] mem_rdata,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,

    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,

    input  logic                  m_axil_bvalid,
    input  logic [1:0]            m_axil_bresp,
    output logic                  m_axil_bready,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,

    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,

    output logic [ERR_WIDTH-1:0]  err_count
);

    bridge_state_t         state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [2:0]            prot_q, prot_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic [ERR_WIDTH-1:0]  err_inc;
    logic                  aw_fire, w_fire;

    assign aw_fire = awvalid_q && m_axil_awready;
    assign w_fire  = wvalid_q && m_axil_wready;
    // Saturating increment, applied only when a non-OKAY response completes
    assign err_inc = (err_q == {ERR_WIDTH{1'b1}}) ? err_q : err_q + ERR_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        mem_ready_d = 1'b0;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        prot_d      = prot_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    // Word-align so the slave always returns the full word
                    addr_d             = mem_addr & ~ADDR_WIDTH'(3);
                    wdata_d            = mem_wdata;
                    wstrb_d            = mem_wstrb;
                    prot_d             = AXI_PROT;
                    prot_d[PROT_INSTR] = AXI_PROT[PROT_INSTR] | mem_instr;
                    if (|mem_wstrb) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d  = WAIT_B;
                    bready_d = 1'b1;
                end
            end
            WAIT_B: begin
                if (m_axil_bvalid) begin
                    bready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
                    if (m_axil_bresp != RESP_OKAY) begin
                        err_d = err_inc;
                    end
                end
            end
            RD: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = WAIT_R;
                end
            end
            WAIT_R: begin
                if (m_axil_rvalid) begin
                    rready_d    = 1'b0;
                    rdata_d     = m_axil_rdata;
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
                    if (m_axil_rresp != RESP_OKAY) begin
                        err_d = err_inc;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            prot_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            mem_ready_q <= mem_ready_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            prot_q      <= prot_d;
            err_q       <= err_d;
        end
    end

    assign mem_ready      = mem_ready_q;
    assign mem_rdata      = rdata_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = prot_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = prot_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign err_count      = err_q;

endmodule
